box_outline_writer: RTL and testbench
=====================================

# box_outline_writer

Draws a one-pixel rectangle outline into the interleaved RGB image buffer, so a detected bounding box can be displayed or exported. It is the write-side counterpart of the bounding-box scanner: it consumes the same xMin/xMax/yMin/yMax coordinates and writes the buffer using the same addressing (three 16-bit words per pixel, R/G/B order, row-major). It masters the buffer's write port with a waitrequest handshake and signals completion with a level `done`.

## Interface
- WIDTH, 100, image width in pixels
- HEIGHT, 100, image height in pixels

- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- start  in  1  request to draw; sampled in IDLE or DONE only
- done  out  1  high while in DONE (outline fully written)
- xMin, xMax  in  11  box column bounds, inclusive; sampled on accepted start
- yMin, yMax  in  11  box row bounds, inclusive; sampled on accepted start
- colour_r, colour_g, colour_b  in  16  outline colour words; sampled on accepted start
- addr  out  32  word address = y*WIDTH*3 + x*3 + c, c = 0 (R), 1 (G), 2 (B)
- wrdata  out  16  colour word for component c
- wren  out  1  write request
- waitrequest  in  1  buffer stall; a write is accepted on a cycle with wren=1 and waitrequest=0

## Operation
- States: IDLE, DRAW, DONE. Reset forces IDLE.
- Outputs on reset: done=0, wren=0, addr=0, wrdata=0.
- IDLE/DONE with start=1: latch the bounds and colours.
  - Clamp xMin and xMax to WIDTH-1, and yMin and yMax to HEIGHT-1.
  - If xMin>xMax or yMin>yMax after clamping (empty box, e.g. the scanner's reset values 99/0), go directly to DONE with no writes.
  - Otherwise go to DRAW.
- DRAW traversal order:
  - Top edge: y=yMin, x=xMin..xMax.
  - Bottom edge: y=yMax, x=xMin..xMax; skipped if yMax==yMin.
  - Left edge: x=xMin, y=yMin+1..yMax-1.
  - Right edge: x=xMax, y=yMin+1..yMax-1; skipped if xMax==xMin.
  - Left and right edges are empty when the height is 2 or less.
- Each pixel produces three writes, c = 0, 1, 2, with wrdata = colour_r, colour_g, colour_b respectively.
- Write count = 3*P, where w = xMax-xMin+1 and h = yMax-yMin+1:
  - P = w if h==1;
  - P = h if w==1;
  - P = 2w + 2(h-2) otherwise.
- Each pixel is written exactly once; no pixel is written twice.
- After the last accepted write, go to DONE; `done` stays high until the next accepted start.
- start during DRAW is ignored.
- rst during DRAW aborts: the in-flight write is dropped and no partial-state resume occurs.
- Address arithmetic is unsigned and at least 32 bits wide; no overflow is possible for WIDTH, HEIGHT up to 2047.

## Timing
- start accepted at edge N: wren is high with the first address from cycle N+1. done drops at N+1 when leaving DONE.
- While waitrequest=1, addr, wrdata and wren are held stable and the sequence does not advance.
- With waitrequest=0 continuously, one write is accepted per cycle and wren never deasserts mid-sequence.
- done rises on the cycle after the last accepted write, and wren=0 that same cycle.
- Empty box: done is high at N+1; wren never asserts.
- rst high at an edge: wren=0 and done=0 from the next cycle onward; normal operation resumes from IDLE.
- start held high continuously in DONE re-triggers a redraw on every entry to DONE; this is legal.

## Test plan
- Box (10,12)-(13,14), WIDTH=HEIGHT=100, colour 0x00FF/0x0000/0x0000, waitrequest=0 → 30 writes on cycles N+1..N+30.
  - First write: addr 3630, data 0x00FF; second: addr 3631, data 0x0000.
  - Last pixel (13,13), B: addr 3941.
  - done high at N+31.
- 1x1 box (5,5) → exactly 3 writes to addr 1515, 1516, 1517; done at N+4.
- Empty box xMin=99, xMax=0, yMin=99, yMax=0 → wren stays 0 and done=1 at N+1. Separately, xMax=200 with xMin=98, yMin=yMax=0 → clamps to 98..99, 6 writes, addresses 294..299.
- waitrequest=1 for 5 cycles during the 2nd write of the first test → addr 3631 and wrdata held stable, no write skipped or duplicated, done at N+36.
- rst pulsed for 1 cycle at the 10th write of the first test → wren=0 and done=0 next cycle. A new start then reproduces the full 30-write sequence from addr 3630.
- Box (0,0)-(99,99) → P=396, 1188 writes, last write addr 29699 (pixel (99,98), B); no address exceeds 29999.

Source files
------------

// File: rtl/box_outline_writer.sv
// Writes a one-pixel rectangle outline into an interleaved RGB word buffer
// (3 words per pixel, row-major) through a waitrequest-stalled write port.
module box_outline_writer #(
  parameter  int unsigned WIDTH  = 100,
  parameter  int unsigned HEIGHT = 100,
  localparam int unsigned CW     = 11,
  localparam int unsigned DW     = 16,
  localparam int unsigned AW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  input  logic [CW-1:0] xMin,
  input  logic [CW-1:0] xMax,
  input  logic [CW-1:0] yMin,
  input  logic [CW-1:0] yMax,
  input  logic [DW-1:0] colour_r,
  input  logic [DW-1:0] colour_g,
  input  logic [DW-1:0] colour_b,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wrdata,
  output logic          wren,
  input  logic          waitrequest
);

  localparam int unsigned   ROW_WORDS = WIDTH * 3;
  localparam logic [CW-1:0] X_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  typedef enum logic [1:0] {P_TOP, P_BOTTOM, P_LEFT, P_RIGHT} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]    c_q, c_d;
  logic [CW-1:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d, y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic [DW-1:0] col_r_q, col_r_d, col_g_q, col_g_d, col_b_q, col_b_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wrdata_d;
  logic          wren_d, done_d;

  // Clamped start bounds and successor-pixel helpers
  logic [CW-1:0] x_lo_cl, x_hi_cl, y_lo_cl, y_hi_cl;
  logic          empty_box, has_sides, more_rows;
  logic [CW-1:0] nx, ny;
  phase_t        nph;
  logic          last_pix;

  assign x_lo_cl   = (xMin > X_LAST) ? X_LAST : xMin;
  assign x_hi_cl   = (xMax > X_LAST) ? X_LAST : xMax;
  assign y_lo_cl   = (yMin > Y_LAST) ? Y_LAST : yMin;
  assign y_hi_cl   = (yMax > Y_LAST) ? Y_LAST : yMax;
  assign empty_box = (x_lo_cl > x_hi_cl) || (y_lo_cl > y_hi_cl);
  assign has_sides = ((12)'(y_lo_q) + 12'd1) < (12)'(y_hi_q);
  assign more_rows = ((12)'(y_q) + 12'd1) < (12)'(y_hi_q);

  // Successor pixel along top, bottom, left, right edges
  always_comb begin
    nx       = x_q;
    ny       = y_q;
    nph      = phase_q;
    last_pix = 1'b0;
    case (phase_q)
      P_TOP, P_BOTTOM: begin
        if (x_q != x_hi_q) begin
          nx = x_q + CW'(1);
        end else if (phase_q == P_TOP && y_hi_q != y_lo_q) begin
          nph = P_BOTTOM;
          nx  = x_lo_q;
          ny  = y_hi_q;
        end else if (has_sides) begin
          nph = P_LEFT;
          nx  = x_lo_q;
          ny  = y_lo_q + CW'(1);
        end else begin
          last_pix = 1'b1;
        end
      end
      P_LEFT: begin
        if (more_rows) begin
          ny = y_q + CW'(1);
        end else if (x_hi_q != x_lo_q) begin
          nph = P_RIGHT;
          nx  = x_hi_q;
          ny  = y_lo_q + CW'(1);
        end else begin
          last_pix = 1'b1;
        end
      end
      default: begin
        if (more_rows) ny = y_q + CW'(1);
        else           last_pix = 1'b1;
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    x_lo_d  = x_lo_q;
    x_hi_d  = x_hi_q;
    y_lo_d  = y_lo_q;
    y_hi_d  = y_hi_q;
    col_r_d = col_r_q;
    col_g_d = col_g_q;
    col_b_d = col_b_q;
    wren_d  = wren;
    done_d  = done;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_lo_d  = x_lo_cl;
          x_hi_d  = x_hi_cl;
          y_lo_d  = y_lo_cl;
          y_hi_d  = y_hi_cl;
          col_r_d = colour_r;
          col_g_d = colour_g;
          col_b_d = colour_b;
          if (empty_box) begin
            state_d = DONE;
            done_d  = 1'b1;
            wren_d  = 1'b0;
          end else begin
            state_d = DRAW;
            phase_d = P_TOP;
            x_d     = x_lo_cl;
            y_d     = y_lo_cl;
            c_d     = 2'd0;
            wren_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      default: begin
        if (!waitrequest) begin
          if (c_q != 2'd2) begin
            c_d = c_q + 2'd1;
          end else if (last_pix) begin
            state_d = DONE;
            wren_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d     = nx;
            y_d     = ny;
            phase_d = nph;
            c_d     = 2'd0;
          end
        end
      end
    endcase
    addr_d = AW'(y_d) * AW'(ROW_WORDS) + AW'(x_d) * AW'(3) + AW'(c_d);
    case (c_d)
      2'd0:    wrdata_d = col_r_d;
      2'd1:    wrdata_d = col_g_d;
      default: wrdata_d = col_b_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= P_TOP;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      x_lo_q  <= '0;
      x_hi_q  <= '0;
      y_lo_q  <= '0;
      y_hi_q  <= '0;
      col_r_q <= '0;
      col_g_q <= '0;
      col_b_q <= '0;
      addr    <= '0;
      wrdata  <= '0;
      wren    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      x_lo_q  <= x_lo_d;
      x_hi_q  <= x_hi_d;
      y_lo_q  <= y_lo_d;
      y_hi_q  <= y_hi_d;
      col_r_q <= col_r_d;
      col_g_q <= col_g_d;
      col_b_q <= col_b_d;
      addr    <= addr_d;
      wrdata  <= wrdata_d;
      wren    <= wren_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_box_outline_writer.sv
// Scoreboard bench for box_outline_writer: a reference model lists the outline
// pixels edge by edge, and a monitor checks every accepted write against it.
module tb_box_outline_writer;

  localparam int unsigned WIDTH  = 100;
  localparam int unsigned HEIGHT = 100;

  logic        clk = 1'b0;
  logic        rst, start, done, wren, waitrequest;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic [15:0] colour_r, colour_g, colour_b, wrdata;
  logic [31:0] addr;

  box_outline_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .colour_r(colour_r), .colour_g(colour_g), .colour_b(colour_b),
    .addr(addr), .wrdata(wrdata), .wren(wren), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] max_addr  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: clamp, enumerate outline pixels in drawing order, expand to RGB words
  task automatic load_model(input int xl, input int xh, input int yl, input int yh,
                            input logic [15:0] r, input logic [15:0] g,
                            input logic [15:0] b, output int nwr);
    int px[$];
    int py[$];
    logic [15:0] col[3];
    col[0] = r; col[1] = g; col[2] = b;
    if (xl > WIDTH - 1)  xl = WIDTH - 1;
    if (xh > WIDTH - 1)  xh = WIDTH - 1;
    if (yl > HEIGHT - 1) yl = HEIGHT - 1;
    if (yh > HEIGHT - 1) yh = HEIGHT - 1;
    nwr = 0;
    if (xl > xh || yl > yh) return;
    for (int x = xl; x <= xh; x++) begin px.push_back(x); py.push_back(yl); end
    if (yh != yl)
      for (int x = xl; x <= xh; x++) begin px.push_back(x); py.push_back(yh); end
    for (int y = yl + 1; y <= yh - 1; y++) begin px.push_back(xl); py.push_back(y); end
    if (xh != xl)
      for (int y = yl + 1; y <= yh - 1; y++) begin px.push_back(xh); py.push_back(y); end
    foreach (px[i]) begin
      for (int c = 0; c < 3; c++) begin
        wr_t e;
        e.a = 32'(py[i] * int'(WIDTH) * 3 + px[i] * 3 + c);
        e.d = col[c];
        exp_q.push_back(e);
        nwr++;
      end
    end
  endtask

  // Monitor: pops one expectation per accepted write and checks stall holding
  initial begin
    logic        prev_stall;
    logic [31:0] pa;
    logic [15:0] pd;
    wr_t         e;
    prev_stall = 1'b0;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("hold_addr", 64'(addr), 64'(pa));
        check("hold_data", 64'(wrdata), 64'(pd));
        check("hold_wren", 64'(wren), 64'(1));
      end
      if (wren && !waitrequest && !rst) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 64'(addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(addr), 64'(e.a));
          check("wr_data", 64'(wrdata), 64'(e.d));
        end
        last_addr = addr;
        if (addr > max_addr) max_addr = addr;
      end
      prev_stall = wren && waitrequest && !rst;
      pa = addr;
      pd = wrdata;
    end
  end

  // mode 0: no stalls, 1: random stalls and ignored starts, 2: 5-cycle stall on
  // the 2nd write, 3: reset abort on the 10th write
  task automatic run_box(input int xl, input int xh, input int yl, input int yh,
                         input logic [15:0] r, input logic [15:0] g,
                         input logic [15:0] b, input int mode);
    int nwr, left, acc, stall5;
    load_model(xl, xh, yl, yh, r, g, b, nwr);
    xMin = 11'(xl); xMax = 11'(xh); yMin = 11'(yl); yMax = 11'(yh);
    colour_r = r; colour_g = g; colour_b = b;
    waitrequest = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (nwr == 0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("empty_wren", 64'(wren), 64'(0));
        check("empty_done", 64'(done), 64'(1));
        @(posedge clk); #1;
      end
      return;
    end
    left = nwr;
    stall5 = 0;
    while (left > 0) begin
      acc = nwr - left;
      waitrequest = 1'b0;
      if (mode == 1) begin
        waitrequest = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 7) == 0);
        xMin = 11'($urandom_range(0, 99)); yMax = 11'($urandom_range(0, 99));
      end else if (mode == 2 && acc == 1 && stall5 < 5) begin
        waitrequest = 1'b1;
        stall5++;
      end else if (mode == 3 && acc == 9) begin
        waitrequest = 1'b1;
        rst = 1'b1;
      end
      @(negedge clk);
      check("draw_wren", 64'(wren), 64'(1));
      check("draw_done", 64'(done), 64'(0));
      @(posedge clk); #1;
      if (mode == 3 && acc == 9) begin
        rst = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        check("abort_wren", 64'(wren), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_pending", 64'(exp_q.size()), 64'(nwr - 9));
        exp_q.delete();
        @(posedge clk); #1;
        return;
      end
      if (!waitrequest) left--;
    end
    start = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    check("end_done", 64'(done), 64'(1));
    check("end_wren", 64'(wren), 64'(0));
    check("end_drained", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; waitrequest = 1'b0;
    xMin = '0; xMax = '0; yMin = '0; yMax = '0;
    colour_r = '0; colour_g = '0; colour_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", 64'(done), 64'(0));
    check("rst_wren", 64'(wren), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_wrdata", 64'(wrdata), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_box(10, 13, 12, 14, 16'h00FF, 16'h0000, 16'h0000, 0);
    check("box_last_addr", 64'(last_addr), 64'(3941));
    run_box(5, 5, 5, 5, 16'h1234, 16'h5678, 16'h9ABC, 0);
    check("one_px_last_addr", 64'(last_addr), 64'(1517));
    run_box(99, 0, 99, 0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 0);
    run_box(98, 200, 0, 0, 16'h0001, 16'h0002, 16'h0003, 0);
    check("clamp_last_addr", 64'(last_addr), 64'(299));
    run_box(10, 13, 12, 14, 16'h00FF, 16'h0000, 16'h0000, 2);
    check("stall_last_addr", 64'(last_addr), 64'(3941));
    run_box(10, 13, 12, 14, 16'h00FF, 16'h0000, 16'h0000, 3);
    run_box(10, 13, 12, 14, 16'h00FF, 16'h0000, 16'h0000, 0);
    check("after_abort_last_addr", 64'(last_addr), 64'(3941));
    max_addr = '0;
    run_box(0, 99, 0, 99, 16'hFFFF, 16'h8000, 16'h0001, 0);
    check("full_last_addr", 64'(last_addr), 64'(29699));
    check("full_max_in_range", 64'(max_addr <= 32'd29999), 64'(1));

    for (int t = 0; t < 40; t++) begin
      int lo, hi;
      lo = (t % 8 == 7) ? 90 : 0;
      hi = (t % 8 == 7) ? 150 : 24;
      run_box($urandom_range(lo, hi), $urandom_range(lo, hi),
              $urandom_range(lo, hi), $urandom_range(lo, hi),
              16'($urandom), 16'($urandom), 16'($urandom), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
